// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers,
// with bounded bursts per producer and saturating write/stall statistics.
module async_fifo_wr_arb #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = $clog2(NREQ),
    localparam int BW        = $clog2(BURST_MAX + 1)
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic                       arb_en,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic [IDW-1:0]             gnt_id,
    output logic [CNT_WIDTH-1:0]       wr_cnt,
    output logic [CNT_WIDTH-1:0]       stall_cnt
);

    logic [IDW-1:0]       last_q, last_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [IDW-1:0]       cand;
    logic [IDW-1:0]       scan_idx;
    logic                 any_valid;
    logic                 sticky;
    logic                 stall;

    assign any_valid = |req_valid;
    // burst_q == 0 only after reset: no burst is in progress, so the scan
    // starts above last and the first grant goes to requester 0.
    assign sticky    = req_valid[last_q] && (burst_q != '0) && (burst_q < BW'(BURST_MAX));
    assign winc      = wrst_n & arb_en & any_valid & ~wfull;
    assign stall     = arb_en & any_valid & wfull;

    always_comb begin
        cand     = last_q;
        scan_idx = last_q;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = IDW'((int'(last_q) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                cand = scan_idx;
            end
        end
        if (sticky) begin
            cand = last_q;
        end
    end

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand == IDW'(i)) begin
                req_ready[i] = winc;
                wdata        = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt_id    = cand;
    assign wr_cnt    = wr_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        last_d      = last_q;
        burst_d     = burst_q;
        wr_cnt_d    = wr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (winc) begin
            if (cand == last_q) begin
                if (burst_q < BW'(BURST_MAX)) begin
                    burst_d = burst_q + 1'b1;
                end
            end else begin
                last_d  = cand;
                burst_d = BW'(1);
            end
            if (wr_cnt_q != '1) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            last_q      <= IDW'(NREQ - 1);
            burst_q     <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            last_q      <= last_d;
            burst_q     <= burst_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Bench for async_fifo_wr_arb: directed phases push expected writes and
// counter values; a negedge monitor pops and compares against the DUT.
module tb_async_fifo_wr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CW   = 16;

    logic           wclk = 1'b0;
    logic           wrst_n;
    logic           arb_en;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic           wfull;
    logic           winc;
    logic [DW-1:0]  wdata;
    logic [1:0]     gnt_id;
    logic [CW-1:0]  wr_cnt;
    logic [CW-1:0]  stall_cnt;

    async_fifo_wr_arb #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .BURST_MAX(4), .CNT_WIDTH(CW)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wfull(wfull), .winc(winc), .wdata(wdata), .gnt_id(gnt_id),
        .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 wclk = ~wclk;

    // Handshake: requester i transfers at a rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready is one-hot and only set with winc.

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]   exp_q[$];
    string           chk_name_q[$];
    int              chk_sel_q[$];
    logic [31:0]     chk_act_q[$];
    logic [31:0]     chk_exp_q[$];

    logic [NREQ-1:0] hs_s = '0;
    logic            w_s  = 1'b0;
    logic [DW-1:0]   d_s  = '0;

    logic [3:0]      cnt[NREQ];
    logic [3:0]      lim[NREQ];
    logic            fifo_mode;
    logic [DW-1:0]   fifo_q[$];
    logic [DW-1:0]   rd_tab[24];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge wclk) begin : monitor
        logic [DW-1:0] e;
        logic [31:0]   act;
        string         nm;
        int            sel;
        logic [31:0]   cact;
        logic [31:0]   cexp;
        hs_s = req_valid & req_ready;
        w_s  = winc;
        d_s  = wdata;
        if (winc) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got wdata=0x%0h gnt=%0d, required no write", wdata, gnt_id);
            end else begin
                e = exp_q.pop_front();
                compare("wdata", 32'(wdata), 32'(e));
                compare("gnt_id", 32'(gnt_id), 32'(e[7:4]));
                compare("req_ready", 32'(req_ready), 32'(4'b0001 << e[5:4]));
            end
        end else begin
            compare("req_ready_idle", 32'(req_ready), 32'd0);
        end
        if (wfull) begin
            compare("winc_while_full", 32'(winc), 32'd0);
        end
        while (chk_sel_q.size() > 0) begin
            nm   = chk_name_q.pop_front();
            sel  = chk_sel_q.pop_front();
            cact = chk_act_q.pop_front();
            cexp = chk_exp_q.pop_front();
            case (sel)
                0:       act = 32'(wr_cnt);
                1:       act = 32'(stall_cnt);
                2:       act = cact;
                3:       act = 32'(exp_q.size());
                default: act = 32'(winc);
            endcase
            compare(nm, act, cexp);
        end
    end

    // sel: 0 wr_cnt, 1 stall_cnt, 2 bench-carried value, 3 pending writes, 4 winc
    task automatic push_chk(input string name, input int sel, input logic [31:0] act, input logic [31:0] exp);
        chk_name_q.push_back(name);
        chk_sel_q.push_back(sel);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = {4'(i), cnt[i]};
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 4'd0;
            lim[i] = 4'd0;
        end
        drive_data();
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_s[i]) begin
                cnt[i] = cnt[i] + 4'd1;
                if (lim[i] != 4'd0 && cnt[i] == lim[i]) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (fifo_mode) begin
            if (w_s) begin
                fifo_q.push_back(d_s);
            end
            wfull = (fifo_q.size() >= 16);
        end
        drive_data();
    endtask

    task automatic push_list(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(base + DW'(k));
        end
    endtask

    initial begin
        wrst_n    = 1'b0;
        arb_en    = 1'b1;
        wfull     = 1'b0;
        req_valid = '1;
        fifo_mode = 1'b0;
        clr_cnt();

        // Reset: no write even with all requesters valid
        push_chk("reset_winc", 4, 32'd0, 32'd0);
        step();
        step();
        req_valid = '0;
        wrst_n    = 1'b1;
        push_chk("reset_wr_cnt", 0, 32'd0, 32'd0);
        push_chk("reset_stall_cnt", 1, 32'd0, 32'd0);

        // All valid: 4-beat bursts rotating 0,1,2,3,0
        clr_cnt();
        req_valid = 4'hF;
        push_list(8'h00, 4);
        push_list(8'h10, 4);
        push_list(8'h20, 4);
        push_list(8'h30, 4);
        exp_q.push_back(8'h04);
        repeat (16) step();
        push_chk("p1_wr_cnt", 0, 32'd0, 32'd16);
        step();
        req_valid = '0;

        // Lone requester 2 keeps the grant; requester 0 then wins one beat
        clr_cnt();
        req_valid = 4'b0100;
        push_list(8'h20, 10);
        repeat (10) step();
        lim[0]       = 4'd1;
        req_valid[0] = 1'b1;
        exp_q.push_back(8'h00);
        push_list(8'h2A, 4);
        repeat (5) step();
        req_valid = '0;
        lim[0]    = 4'd0;
        push_chk("p2_wr_cnt", 0, 32'd0, 32'd32);

        // wfull mid-burst: burst count preserved across the stall
        clr_cnt();
        req_valid = 4'b0010;
        push_list(8'h10, 2);
        repeat (2) step();
        req_valid = 4'b1010;
        wfull     = 1'b1;
        repeat (5) step();
        push_chk("p3_stall_cnt", 1, 32'd0, 32'd5);
        push_chk("p3_wr_cnt_held", 0, 32'd0, 32'd34);
        wfull = 1'b0;
        push_list(8'h12, 2);
        push_list(8'h30, 4);
        exp_q.push_back(8'h14);
        repeat (7) step();
        req_valid = '0;
        push_chk("p3_wr_cnt", 0, 32'd0, 32'd41);

        // arb_en low: no writes, no stall counting; resumes on held candidate
        clr_cnt();
        arb_en    = 1'b0;
        req_valid = 4'hF;
        repeat (3) step();
        push_chk("p4_stall_cnt", 1, 32'd0, 32'd5);
        push_chk("p4_wr_cnt", 0, 32'd0, 32'd41);
        arb_en = 1'b1;
        push_list(8'h10, 3);
        exp_q.push_back(8'h20);
        repeat (4) step();
        push_chk("p4_wr_cnt_after", 0, 32'd0, 32'd45);

        // Reset in the middle of requester 3's burst
        push_list(8'h21, 3);
        push_list(8'h30, 2);
        repeat (5) step();
        wrst_n = 1'b0;
        push_chk("p5_reset_winc", 4, 32'd0, 32'd0);
        step();
        wrst_n = 1'b1;
        push_chk("p5_wr_cnt", 0, 32'd0, 32'd0);
        push_chk("p5_stall_cnt", 1, 32'd0, 32'd0);
        exp_q.push_back(8'h00);
        step();
        push_chk("p5_wr_cnt_one", 0, 32'd0, 32'd1);
        wrst_n = 1'b0;
        step();
        req_valid = 4'b1100;
        wrst_n    = 1'b1;
        exp_q.push_back(8'h24);
        step();
        req_valid = '0;

        // Behavioural 16-entry FIFO, reader idle, two 12-byte producers
        clr_cnt();
        lim[0] = 4'd12;
        lim[1] = 4'd12;
        for (int k = 0; k < 4; k++) begin
            rd_tab[k]      = 8'h00 + 8'(k);
            rd_tab[4 + k]  = 8'h10 + 8'(k);
            rd_tab[8 + k]  = 8'h04 + 8'(k);
            rd_tab[12 + k] = 8'h14 + 8'(k);
            rd_tab[16 + k] = 8'h08 + 8'(k);
            rd_tab[20 + k] = 8'h18 + 8'(k);
        end
        for (int k = 0; k < 24; k++) begin
            exp_q.push_back(rd_tab[k]);
        end
        fifo_mode = 1'b1;
        fifo_q.delete();
        wfull     = 1'b0;
        req_valid = 4'b0011;
        for (int n = 0; n < 40 && fifo_q.size() < 16; n++) begin
            step();
        end
        push_chk("p6_fifo_fill", 2, 32'(fifo_q.size()), 32'd16);
        push_chk("p6_wr_cnt_full", 0, 32'd0, 32'd17);
        repeat (3) step();
        push_chk("p6_stall_cnt", 1, 32'd0, 32'd3);
        push_chk("p6_wr_cnt_held", 0, 32'd0, 32'd17);
        for (int k = 0; k < 16; k++) begin
            if (fifo_q.size() > 0) begin
                push_chk("p6_fifo_rd", 2, 32'(fifo_q.pop_front()), 32'(rd_tab[k]));
            end
        end
        wfull = 1'b0;
        repeat (8) step();
        push_chk("p6_fifo_rest", 2, 32'(fifo_q.size()), 32'd8);
        for (int k = 16; k < 24; k++) begin
            if (fifo_q.size() > 0) begin
                push_chk("p6_fifo_rd", 2, 32'(fifo_q.pop_front()), 32'(rd_tab[k]));
            end
        end
        push_chk("p6_wr_cnt", 0, 32'd0, 32'd25);
        push_chk("p6_req_done", 2, 32'(req_valid), 32'd0);

        push_chk("exp_q_empty", 3, 32'd0, 32'd0);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
